// File: rtl/cordic_iteration_controller.sv
// rtl/cordic_iteration_controller.sv - CORDIC load/step sequencer with hyperbolic repeat schedule
module cordic_iteration_controller #(
  parameter int         ITERATIONS      = 16,
  parameter int         REPEAT_A        = 4,
  parameter int         REPEAT_B        = 13,
  parameter logic [1:0] MODE_CIRCULAR   = 2'b00,
  parameter logic [1:0] MODE_LINEAR     = 2'b01,
  parameter logic [1:0] MODE_HYPERBOLIC = 2'b10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       op,
  input  logic       y_sign,
  input  logic       z_sign,
  input  logic       hold,
  output logic       busy,
  output logic       load_en,
  output logic       step_en,
  output logic [4:0] shift_amount,
  output logic       sigma,
  output logic [1:0] mode_q,
  output logic       last_step,
  output logic       done,
  output logic       mode_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [4:0] LAST_K = 5'(ITERATIONS - 1);
  localparam logic [4:0] RPT_A  = 5'(REPEAT_A);
  localparam logic [4:0] RPT_B  = 5'(REPEAT_B);

  logic [1:0] state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] shift_q, shift_d;
  logic [1:0] mode_reg_q, mode_reg_d;
  logic       op_q, op_d;
  logic       err_q, err_d;
  logic       mode_valid;
  logic       in_iter;

  // Hyperbolic steps start at shift 1; every step at or past a repeat slot lags by one.
  function automatic logic [4:0] sched(input logic [1:0] m, input logic [4:0] k);
    logic [4:0] s;
    s = k;
    if (m == MODE_HYPERBOLIC) begin
      s = k + 5'd1;
      if (k >= RPT_A) s = s - 5'd1;
      if (k > RPT_B)  s = s - 5'd1;
    end
    return s;
  endfunction

  assign mode_valid = (mode == MODE_CIRCULAR) || (mode == MODE_LINEAR) ||
                      (mode == MODE_HYPERBOLIC);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    mode_reg_d = mode_reg_q;
    op_d       = op_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        shift_d = 5'd0;
        if (start) begin
          if (mode_valid) begin
            mode_reg_d = mode;
            op_d       = op;
            state_d    = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        cnt_d   = 5'd0;
        shift_d = sched(mode_reg_q, 5'd0);
        state_d = S_ITER;
      end
      S_ITER: begin
        if (!hold) begin
          if (cnt_q == LAST_K) begin
            cnt_d   = 5'd0;
            shift_d = 5'd0;
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + 5'd1;
            shift_d = sched(mode_reg_q, cnt_q + 5'd1);
          end
        end
      end
      S_DONE: begin
        shift_d = 5'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      shift_q    <= 5'd0;
      mode_reg_q <= 2'd0;
      op_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      mode_reg_q <= mode_reg_d;
      op_q       <= op_d;
      err_q      <= err_d;
    end
  end

  assign in_iter      = (state_q == S_ITER);
  assign busy         = (state_q != S_IDLE);
  assign load_en      = (state_q == S_LOAD);
  assign step_en      = in_iter && !hold;
  assign last_step    = step_en && (cnt_q == LAST_K);
  assign done         = (state_q == S_DONE);
  assign shift_amount = shift_q;
  assign mode_q       = mode_reg_q;
  assign mode_err     = err_q;
  // Direction follows the live sign bits, including during hold, so it is valid the moment hold drops.
  assign sigma        = in_iter && (op_q ? y_sign : !z_sign);

endmodule

// File: tb/tb_cordic_iteration_controller.sv
// tb/tb_cordic_iteration_controller.sv - scoreboard bench for cordic_iteration_controller
module tb_cordic_iteration_controller;

  localparam int         IT   = 16;
  localparam int         RA   = 4;
  localparam int         RB   = 13;
  localparam logic [1:0] CIRC = 2'b00;
  localparam logic [1:0] LIN  = 2'b01;
  localparam logic [1:0] HYP  = 2'b10;
  localparam logic [1:0] BAD  = 2'b11;

  logic       clock, reset, start, op, y_sign, z_sign, hold;
  logic [1:0] mode;
  logic       busy, load_en, step_en, sigma, last_step, done, mode_err;
  logic [4:0] shift_amount;
  logic [1:0] mode_q;

  cordic_iteration_controller #(.ITERATIONS(IT), .REPEAT_A(RA), .REPEAT_B(RB)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .op(op),
    .y_sign(y_sign), .z_sign(z_sign), .hold(hold), .busy(busy), .load_en(load_en),
    .step_en(step_en), .shift_amount(shift_amount), .sigma(sigma), .mode_q(mode_q),
    .last_step(last_step), .done(done), .mode_err(mode_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // kind: 0 load, 1 step, 2 done, 3 mode error
  typedef struct {
    int         kind;
    int         cyc;
    logic [4:0] sh;
    bit         last;
  } ev_t;

  ev_t        evq[$];
  bit         exp_busy[int];
  int         exp_hold[int];
  logic [1:0] exp_mode = 2'd0;
  logic       exp_op = 1'b0;
  bit         mon_en = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Hyperbolic sequence built by enumeration: each shift once, repeat slots twice.
  function automatic int ref_sched(input logic [1:0] m, input int k);
    int tbl[$];
    if (m != HYP) return k;
    for (int v = 1; tbl.size() <= k; v++) begin
      tbl.push_back(v);
      if (v == RA || v == RB) tbl.push_back(v);
    end
    return tbl[k];
  endfunction

  ev_t        mon_e;
  logic [4:0] vec, expvec;
  logic       exp_sigma;

  always @(negedge clock) begin
    if (mon_en) begin
      vec       = {load_en, step_en, last_step, done, mode_err};
      exp_sigma = exp_op ? y_sign : !z_sign;
      chk("busy", 32'(busy), 32'(exp_busy.exists(cyc)));
      if (exp_busy.exists(cyc)) chk("mode_q", 32'(mode_q), 32'(exp_mode));
      if (vec != 5'd0) begin
        if (evq.size() == 0) begin
          chk("unexpected_strobe", 32'(vec), 32'd0);
        end else begin
          mon_e = evq.pop_front();
          chk("event_cycle", 32'(cyc), 32'(mon_e.cyc));
          case (mon_e.kind)
            0:       expvec = 5'b10000;
            1:       expvec = {1'b0, 1'b1, mon_e.last, 2'b00};
            2:       expvec = 5'b00010;
            default: expvec = 5'b00001;
          endcase
          chk("strobes", 32'(vec), 32'(expvec));
          if (mon_e.kind == 1) begin
            chk("shift", 32'(shift_amount), 32'(mon_e.sh));
            chk("sigma", 32'(sigma), 32'(exp_sigma));
          end
        end
      end else if (exp_hold.exists(cyc)) begin
        chk("hold_shift", 32'(shift_amount), 32'(exp_hold[cyc]));
        chk("hold_sigma", 32'(sigma), 32'(exp_sigma));
      end else begin
        chk("idle_shift", 32'(shift_amount), 32'd0);
        chk("idle_sigma", 32'(sigma), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_op(input logic [1:0] m, input logic o, input int hold_at, input int hold_len,
                        input int rst_at, input int ign_at);
    int   c, t, endc, ignc, rstc;
    bit   holdc[int];
    logic [1:0] ign_mode;
    c        = cyc;
    exp_mode = m;
    exp_op   = o;
    ign_mode = 2'($urandom_range(0, 2));
    evq.push_back('{0, c + 1, 5'd0, 1'b0});
    exp_busy[c + 1] = 1'b1;
    t    = c + 2;
    rstc = -1;
    for (int k = 0; k < IT; k++) begin
      if (k == hold_at) begin
        for (int h = 0; h < hold_len; h++) begin
          exp_busy[t] = 1'b1;
          exp_hold[t] = ref_sched(m, k);
          holdc[t]    = 1'b1;
          t++;
        end
      end
      evq.push_back('{1, t, 5'(ref_sched(m, k)), (k == IT - 1)});
      exp_busy[t] = 1'b1;
      if (k == rst_at) begin
        rstc = t;
        break;
      end
      t++;
    end
    if (rstc < 0) begin
      evq.push_back('{2, t, 5'd0, 1'b0});
      exp_busy[t] = 1'b1;
      endc = t;
    end else begin
      endc = rstc;
    end
    ignc = (ign_at >= 0) ? c + 2 + ign_at : -1;
    while (cyc <= endc) begin
      start  = (cyc == c) || (cyc == ignc);
      mode   = (cyc == ignc) ? ign_mode : m;
      op     = (cyc == ignc) ? !o : o;
      hold   = holdc.exists(cyc);
      reset  = (cyc == rstc);
      y_sign = 1'($urandom);
      z_sign = 1'($urandom);
      step();
    end
    start = 1'b0;
    hold  = 1'b0;
    reset = 1'b0;
    repeat (2) begin
      y_sign = 1'($urandom);
      z_sign = 1'($urandom);
      step();
    end
  endtask

  task automatic bad_mode();
    evq.push_back('{3, cyc + 1, 5'd0, 1'b0});
    start = 1'b1;
    mode  = BAD;
    step();
    start = 1'b0;
    mode  = CIRC;
    repeat (3) step();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = CIRC; op = 1'b0;
    y_sign = 1'b0; z_sign = 1'b0; hold = 1'b0;
    step();
    step();
    mon_en = 1'b1;
    step();
    reset = 1'b0;
    step();

    run_op(CIRC, 1'b1, -1, 0, -1, -1);
    run_op(HYP,  1'b0, -1, 0, -1, -1);
    run_op(CIRC, 1'b0,  5, 3, -1, -1);
    bad_mode();
    run_op(LIN,  1'b1, -1, 0, -1,  4);
    run_op(CIRC, 1'b0, -1, 0,  7, -1);
    run_op(CIRC, 1'b1, -1, 0, -1, -1);
    run_op(HYP,  1'b1, 13, 2, -1, -1);
    for (int r = 0; r < 8; r++) begin
      run_op(2'($urandom_range(0, 2)), 1'($urandom), int'($urandom_range(0, IT - 1)),
             int'($urandom_range(0, 3)), -1, -1);
    end

    repeat (3) step();
    chk("queue_empty", 32'(evq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_iteration_controller.md
Name: cordic_iteration_controller

Overview:
- Sequencer for the iterative CORDIC vector datapath: the X/Y/Z calculators plus the arctangent/shift tables.
- Accepts a start request with a mode (`CIRCULAR, `HYPERBOLIC, `LINEAR) and an operation (rotation or vectoring).
- Issues the one-cycle load, then one step strobe per iteration with the shift amount and rotation direction, then signals done.
- Owns the hyperbolic repeat-iteration schedule, so the datapath stays purely per-step.

Parameters:
- ITERATIONS, 16: micro-rotation steps per operation, all modes; legal range 2..30.
- REPEAT_A, 4: first hyperbolic shift value executed twice.
- REPEAT_B, 13: second hyperbolic shift value executed twice.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse or level; sampled only in IDLE.
- mode  in  2  `CIRCULAR / `HYPERBOLIC / `LINEAR encodings from CONSTANTS.v; any other value is invalid.
- op  in  1  0 = rotation (drive z to 0), 1 = vectoring (drive y to 0).
- y_sign  in  1  MSB of the current datapath y register.
- z_sign  in  1  MSB of the current datapath angle (z) register.
- hold  in  1  datapath stall; freezes the sequencer in ITER.
- busy  out  1  high from the LOAD cycle through the DONE cycle.
- load_en  out  1  one-cycle strobe: datapath captures its inputs.
- step_en  out  1  datapath performs one micro-rotation this cycle.
- shift_amount  out  5  right-shift applied to x/y this step; also the atan table index.
- sigma  out  1  1 = positive rotation direction (y += x>>s, z -= atan), 0 = negative.
- mode_q  out  2  mode latched at start; held stable while busy.
- last_step  out  1  high with step_en on the final step.
- done  out  1  one-cycle completion pulse.
- mode_err  out  1  one-cycle pulse when start is seen with an invalid mode.

Behaviour:
- Reset values: all outputs 0; state IDLE; step counter 0. Reset wins over every other input in every state, including mid-ITER; outputs are 0 on the cycle after reset is sampled.
- States: IDLE -> LOAD -> ITER -> DONE -> IDLE.
- IDLE, start=1, valid mode: latch mode and op; go to LOAD.
- IDLE, start=1, invalid mode: mode_err=1 for one cycle; stay in IDLE; nothing is latched.
- LOAD:
  - load_en=1 and busy=1; step_en=0.
  - Counter cleared to 0.
  - Unconditional move to ITER. hold is ignored here.
- ITER, hold=0:
  - step_en=1.
  - shift_amount = sched(counter).
  - sigma: rotation (op=0) sigma = ~z_sign; vectoring (op=1) sigma = y_sign.
  - sigma is combinational from the current sign inputs in the same cycle.
  - Counter increments each cycle.
  - last_step=1 when counter = ITERATIONS-1; the next state is DONE.
- ITER, hold=1:
  - step_en=0 and last_step=0.
  - Counter and shift_amount are frozen; sigma still tracks its inputs.
  - State stays ITER.
- DONE: done=1 and busy=1 for one cycle, then IDLE. start is ignored in DONE and must be seen in IDLE.
- Start while busy: ignored. No queueing and no mode_err; mode_q is unchanged.
- Schedule sched(k):
  - `CIRCULAR and `LINEAR: k (0..ITERATIONS-1).
  - `HYPERBOLIC: begins at 1; REPEAT_A and REPEAT_B are each issued on two consecutive steps; the total step count is still ITERATIONS.
  - Hyperbolic, ITERATIONS=16: 1,2,3,4,4,5,6,7,8,9,10,11,12,13,13,14.
  - A repeat value that would fall beyond the final step is simply never reached.
- Latency: start sampled at edge N gives load_en in cycle N+1, the first step_en in N+2, and done in N+ITERATIONS+2 when hold never asserts. Each hold cycle adds one cycle.
- Throughput: the next start is accepted no earlier than the cycle after done. The minimum start-to-start interval is ITERATIONS+3 cycles.
- shift_amount is registered; it is 0 outside ITER.

Test Plan:
- Reset, then `CIRCULAR with op=1 and start=1 for one cycle -> load_en one cycle later; 16 step_en cycles with shift_amount 0..15; last_step on shift 15; done 18 cycles after start; busy high for 18 cycles.
- `HYPERBOLIC with op=0 -> shift_amount sequence exactly 1,2,3,4,4,5,6,7,8,9,10,11,12,13,13,14; done after 16 steps.
- Vectoring: y_sign toggled 1,0,1 on the first three steps -> sigma 1,0,1 in the same cycles; rotation with z_sign=0 -> sigma=1.
- hold=1 for 3 cycles at step 5 -> step_en low and shift_amount stays 5 for those cycles; done delayed by exactly 3 cycles (21 cycles after start).
- mode=2'b11 (none of the three mode encodings from CONSTANTS.v) with start -> one-cycle mode_err pulse; busy stays 0; no load_en. Next, start asserted during ITER of a `LINEAR run -> ignored; mode_q unchanged.
- reset asserted at step 7 of a `CIRCULAR run -> all outputs 0 on the next cycle, no done pulse. A new start afterwards runs normally from shift 0.
